// File: rtl/cla4_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla4_serial_subtractor: a - b - bin, one borrow-lookahead nibble/clock.  |
// | Optional macro SUB_SIGNED_OVF_EN adds the signed-overflow port ovf.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla4_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              br_q, br_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;
`ifdef SUB_SIGNED_OVF_EN
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              ovf_q, ovf_d;
`endif

  // Operands shift right each RUN cycle, so the active nibble is always [3:0].
  logic [3:0] nib_a, nib_b, g, p, brv, nib_d;
  logic       br4;

  always_comb begin
    nib_a  = a_q[3:0];
    nib_b  = b_q[3:0];
    g      = ~nib_a & nib_b;
    p      = ~(nib_a ^ nib_b);
    brv[0] = br_q;
    brv[1] = g[0] | (p[0] & br_q);
    brv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_q);
    brv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_q);
    br4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & br_q);
    nib_d  = nib_a ^ nib_b ^ brv;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    idx_d   = idx_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
`ifdef SUB_SIGNED_OVF_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          idx_d   = '0;
          res_d   = '0;
`ifdef SUB_SIGNED_OVF_EN
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        br_d  = br4;
        idx_d = idx_q + 1'b1;
        // New nibble enters at the top; after NIB shifts nibble 0 sits at the bottom.
        res_d = (res_q >> 4) | (WIDTH'(nib_d) << (WIDTH - 4));
        if (idx_q == LAST_IDX) begin
          diff_d  = res_d;
          bout_d  = br4;
          zero_d  = (res_d == '0);
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = (sa_q != sb_q) & (res_d[WIDTH-1] != sa_q);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
`ifdef SUB_SIGNED_OVF_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla4_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla4_serial_subtractor: directed and back-to-back checks.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cla4_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         in_ready, out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout, zero;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  cla4_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for out_valid; lat counts edges after acceptance.
  task automatic run_req(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                         output int lat, output logic ok);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    a = ra; b = rb; bin = rbin; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, diff, bout, zero} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b diff=%h bout=%b zero=%b, want 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, zero);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic ok;
    run_req(16'h1234, 16'h0235, 1'b0, lat, ok);
    checks++;
    if (!ok || lat != 4) begin
      errors++;
      $display("FAIL latency: got valid=%b after %0d edges, want 1 after 4", ok, lat);
    end
    checks++;
    if ({diff, bout, zero} !== {16'h0FFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic: got diff=%h bout=%b zero=%b, want 0fff 0 0", diff, bout, zero);
    end
  endtask

  task automatic test_wrap();
    int lat; logic ok;
    run_req(16'h0000, 16'h0001, 1'b0, lat, ok);
    checks++;
    if (!ok || {diff, bout, zero} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap: got valid=%b diff=%h bout=%b zero=%b, want 1 ffff 1 0",
               ok, diff, bout, zero);
    end
    run_req(16'h00FF, 16'h00FE, 1'b1, lat, ok);
    checks++;
    if (!ok || {diff, bout, zero} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_bin: got valid=%b diff=%h bout=%b zero=%b, want 1 0000 0 1",
               ok, diff, bout, zero);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic ok; int bad = 0;
    tick();
    out_ready = 1'b0;
    run_req(16'hA5A5, 16'h1111, 1'b1, lat, ok);
    checks++;
    if (!ok || {diff, bout, zero} !== {16'h9493, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_result: got valid=%b diff=%h bout=%b zero=%b, want 1 9493 0 0",
               ok, diff, bout, zero);
    end
    for (int i = 0; i < 10; i++) begin
      a = 16'(i * 16'h1357); b = ~a; start = i[0];
      tick();
      if (!out_valid || in_ready || diff !== 16'h9493 || bout !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 16'h9493}) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b diff=%h, want 1 0 9493",
               in_ready, out_valid, diff);
    end
    // out_ready while idle must not disturb anything
    tick();
    checks++;
    if ({in_ready, out_valid, diff} !== {1'b1, 1'b0, 16'h9493}) begin
      errors++;
      $display("FAIL idle_hold: got rdy=%b vld=%b diff=%h, want 1 0 9493",
               in_ready, out_valid, diff);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; logic ok;
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, diff, bout, zero} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_rst: got rdy=%b vld=%b diff=%h bout=%b zero=%b, want 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, zero);
    end
    tick();
    rst = 1'b0;
    tick();
    run_req(16'h4321, 16'h1234, 1'b0, lat, ok);
    checks++;
    if (!ok || {diff, bout, zero} !== {16'h30ED, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_rst: got valid=%b diff=%h bout=%b, want 1 30ed 0", ok, diff, bout);
    end
  endtask

`ifdef SUB_SIGNED_OVF_EN
  task automatic test_ovf();
    int lat; logic ok;
    run_req(16'h8000, 16'h0001, 1'b0, lat, ok);
    checks++;
    if (!ok || {diff, ovf, bout} !== {16'h7FFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_neg: got diff=%h ovf=%b bout=%b, want 7fff 1 0", diff, ovf, bout);
    end
    run_req(16'h7FFF, 16'hFFFF, 1'b0, lat, ok);
    checks++;
    if (!ok || {diff, ovf, bout} !== {16'h8000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pos: got diff=%h ovf=%b bout=%b, want 8000 1 1", diff, ovf, bout);
    end
    run_req(16'h0005, 16'h0003, 1'b0, lat, ok);
    checks++;
    if (!ok || {diff, ovf} !== {16'h0002, 1'b0}) begin
      errors++;
      $display("FAIL ovf_none: got diff=%h ovf=%b, want 0002 0", diff, ovf);
    end
  endtask
`endif

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [W:0]   exp_full;
    logic [W-1:0] ea, eb;
    logic         eovf;
    logic         pending = 1'b0;
    int           results = 0;
    int           last = -1;
    int           cyc = 0;
    while (!in_ready) tick();
    out_ready = 1'b1;
    start = 1'b1;
    exp_full = '0; eovf = 1'b0; ea = '0; eb = '0;
    while (results < N && cyc < N * 6 + 50) begin
      if (out_valid) begin
        checks++;
        if (!pending || {bout, diff} !== exp_full || zero !== (exp_full[W-1:0] == '0)) begin
          errors++;
          $display("FAIL b2b[%0d]: a=%h b=%h got bout=%b diff=%h zero=%b, want %b %h",
                   results, ea, eb, bout, diff, zero, exp_full[W], exp_full[W-1:0]);
        end
`ifdef SUB_SIGNED_OVF_EN
        checks++;
        if (ovf !== eovf) begin
          errors++;
          $display("FAIL b2b_ovf[%0d]: got %b, want %b", results, ovf, eovf);
        end
`endif
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            errors++;
            $display("FAIL b2b_rate[%0d]: got %0d cycles, want 6", results, cyc - last);
          end
        end
        last = cyc;
        pending = 1'b0;
        results++;
      end
      if (in_ready) begin
        ea = W'($urandom); eb = W'($urandom);
        if (results % 7 == 0) eb = ea;
        a = ea; b = eb; bin = 1'($urandom);
        exp_full = {1'b0, ea} - {1'b0, eb} - {{W{1'b0}}, bin};
        eovf = (ea[W-1] != eb[W-1]) && (exp_full[W-1] != ea[W-1]);
        pending = 1'b1;
      end else begin
        // Scramble inputs while a request is in flight.
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (results != N) begin
      errors++;
      $display("FAIL b2b_count: got %0d results, want %0d", results, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_midrun();
`ifdef SUB_SIGNED_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
